// File: rtl/imem_loader.sv
// Byte-stream program loader: packs a framed, XOR-checksummed image into 32-bit words,
// writes them to instruction memory from BASE_ADDR upward, and holds the core in reset until done.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst_n,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned LEN_W = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_e;

    state_e             state_q, state_d;
    logic               rx_ready_q, rx_ready_d;
    logic               imem_we_q, imem_we_d;
    logic [31:0]        imem_addr_q, imem_addr_d;
    logic [31:0]        imem_wdata_q, imem_wdata_d;
    logic               core_rst_n_q, core_rst_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [7:0]         len_lo_q, len_lo_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   word_idx_q, word_idx_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [23:0]        word_buf_q, word_buf_d;
    logic [7:0]         csum_q, csum_d;
    logic               accept;
    logic [LEN_W-1:0]   len_new;

    assign accept  = rx_valid && rx_ready_q;
    assign len_new = {rx_data, len_lo_q};

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        word_idx_d   = word_idx_q;
        byte_cnt_d   = byte_cnt_q;
        word_buf_d   = word_buf_q;
        csum_d       = csum_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_LEN0;
                    len_d      = '0;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    word_buf_d = '0;
                    csum_d     = '0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    len_lo_d = rx_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_d = len_new;
                    if (len_new == '0)                   state_d = S_CSUM;
                    else if (32'(len_new) > MAX_WORDS)   state_d = S_ERROR;
                    else                                 state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d     = csum_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: word_buf_d[7:0]   = rx_data;
                        2'd1: word_buf_d[15:8]  = rx_data;
                        2'd2: word_buf_d[23:16] = rx_data;
                        default: begin
                            imem_we_d    = 1'b1;
                            imem_wdata_d = {rx_data, word_buf_q};
                            imem_addr_d  = BASE_ADDR + (32'(word_idx_q) << 2);
                            word_idx_d   = word_idx_q + LEN_W'(1);
                            if (word_idx_q + LEN_W'(1) == len_q) state_d = S_CSUM;
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase

        rx_ready_d   = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                       (state_d == S_DATA) || (state_d == S_CSUM);
        busy_d       = rx_ready_d;
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERROR);
        // Core leaves reset one cycle after DONE entry, so the final write has retired
        core_rst_n_d = (state_q == S_DONE) && (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= '0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            len_lo_q     <= '0;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
            word_buf_q   <= '0;
            csum_q       <= '0;
        end else begin
            state_q      <= state_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            word_buf_q   <= word_buf_d;
            csum_q       <= csum_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst_n = core_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: frames are built in the bench and the
// expected writes, timing and final status are derived from the frame contents.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready, imem_we, core_rst_n, busy, done, error;
    logic [31:0] imem_addr, imem_wdata;

    int errors = 0;
    int checks = 0;
    int stalls = 0;

    logic [31:0] pay[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    time         wr_time_q[$];
    time         acc4_q[$];

    imem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
            wr_time_q.push_back($time);
        end
    end

    function automatic logic [7:0] payload_xor();
        logic [7:0] x = 8'h00;
        foreach (pay[i]) x = x ^ pay[i][7:0] ^ pay[i][15:8] ^ pay[i][23:16] ^ pay[i][31:24];
        return x;
    endfunction

    task automatic clear_log();
        wr_addr_q.delete(); wr_data_q.delete(); wr_time_q.delete(); acc4_q.delete();
        stalls = 0;
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk); rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_data = b; rx_valid = 1'b1;
        w = 0;
        while (!rx_ready && w < 20) begin
            @(negedge clk); w++; stalls++;
        end
        if (!rx_ready) begin
            checks++; errors++;
            $display("FAIL send_byte timeout: byte %02h not accepted, rx_ready=%b required 1", b, rx_ready);
        end else begin
            @(posedge clk);
        end
    endtask

    // Sends LEN, the words in pay, and the given checksum byte; ends at the negedge after CSUM
    task automatic send_frame(input logic [15:0] n, input logic [7:0] cs, input int maxgap);
        send_byte(n[7:0], 0);
        send_byte(n[15:8], 0);
        foreach (pay[i]) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] w = pay[i];
                send_byte(w[8*k +: 8], $urandom_range(0, maxgap));
            end
            acc4_q.push_back($time);
        end
        send_byte(cs, $urandom_range(0, maxgap));
        @(negedge clk); rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b want 0", rx_ready); end
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_imem_we got %b want 0", imem_we); end
        checks++; if (imem_addr !== 32'h0000_1000) begin errors++; $display("FAIL reset_imem_addr got %h want 00001000", imem_addr); end
        checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_imem_wdata got %h want 0", imem_wdata); end
        checks++; if ({core_rst_n, busy, done, error} !== 4'b0000) begin errors++; $display("FAIL reset_status got %b want 0000", {core_rst_n, busy, done, error}); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (rx_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_no_ready got rdy=%b busy=%b want 0 0", rx_ready, busy); end
    endtask

    task automatic test_single();
        clear_log();
        pay = '{32'h0010_0513};
        do_start();
        checks++; if (busy !== 1'b1 || rx_ready !== 1'b1) begin errors++; $display("FAIL single_busy got busy=%b rdy=%b want 1 1", busy, rx_ready); end
        // 13^05^10^00 = 06
        send_frame(16'd1, payload_xor(), 0);
        checks++; if (wr_addr_q.size() != 1) begin errors++; $display("FAIL single_nwr got %0d want 1", wr_addr_q.size()); end
        else begin
            checks++; if (wr_addr_q[0] !== 32'h1000 || wr_data_q[0] !== 32'h0010_0513) begin errors++; $display("FAIL single_wr got %h/%h want 00001000/00100513", wr_addr_q[0], wr_data_q[0]); end
        end
        checks++; if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done got d=%b e=%b b=%b want 1 0 0", done, error, busy); end
        checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL single_crst_early got %b want 0", core_rst_n); end
        @(negedge clk);
        checks++; if (core_rst_n !== 1'b1) begin errors++; $display("FAIL single_crst got %b want 1", core_rst_n); end
    endtask

    task automatic test_back_to_back();
        clear_log();
        pay.delete();
        for (int i = 0; i < 3; i++) pay.push_back($urandom);
        do_start();
        send_frame(16'd3, payload_xor(), 0);
        checks++; if (stalls != 0) begin errors++; $display("FAIL b2b_stall got %0d stalls want 0", stalls); end
        checks++; if (wr_addr_q.size() != 3) begin errors++; $display("FAIL b2b_nwr got %0d want 3", wr_addr_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr_q[i] !== 32'h1000 + 32'(4 * i) || wr_data_q[i] !== pay[i] || wr_time_q[i] != acc4_q[i] + 5) begin
                    errors++;
                    $display("FAIL b2b_wr%0d got %h/%h@%0t want %h/%h@%0t", i, wr_addr_q[i], wr_data_q[i], wr_time_q[i],
                             32'h1000 + 32'(4 * i), pay[i], acc4_q[i] + 5);
                end
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", done); end
    endtask

    task automatic test_bad_csum();
        clear_log();
        pay = '{32'h0010_0513};
        do_start();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL restart_clears_done got %b want 0", done); end
        send_frame(16'd1, 8'h57, 0);
        repeat (2) @(negedge clk);
        checks++; if (error !== 1'b1 || done !== 1'b0 || core_rst_n !== 1'b0) begin errors++; $display("FAIL badcs got e=%b d=%b crst=%b want 1 0 0", error, done, core_rst_n); end
        checks++; if (wr_addr_q.size() != 1) begin errors++; $display("FAIL badcs_nwr got %0d want 1", wr_addr_q.size()); end
    endtask

    task automatic test_too_long();
        clear_log();
        do_start();
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL restart_clears_error got %b want 0", error); end
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        @(negedge clk); rx_valid = 1'b0;
        checks++; if (error !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0) begin errors++; $display("FAIL toolong got e=%b b=%b r=%b want 1 0 0", error, busy, rx_ready); end
        repeat (4) @(negedge clk);
        checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL toolong_nwr got %0d want 0", wr_addr_q.size()); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 5; f++) begin
            int n = $urandom_range(1, 6);
            bit bad = ($urandom_range(0, 3) == 0);
            logic [7:0] cs;
            clear_log();
            pay.delete();
            for (int i = 0; i < n; i++) pay.push_back($urandom);
            cs = payload_xor();
            if (bad) cs = cs ^ 8'(($urandom_range(1, 255)));
            do_start();
            send_frame(16'(n), cs, 2);
            checks++; if (wr_addr_q.size() != n) begin errors++; $display("FAIL rnd%0d_nwr got %0d want %0d", f, wr_addr_q.size(), n); end
            else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (wr_addr_q[i] !== 32'h1000 + 32'(4 * i) || wr_data_q[i] !== pay[i] || wr_time_q[i] != acc4_q[i] + 5) begin
                        errors++;
                        $display("FAIL rnd%0d_wr%0d got %h/%h want %h/%h", f, i, wr_addr_q[i], wr_data_q[i], 32'h1000 + 32'(4 * i), pay[i]);
                    end
                end
            end
            checks++; if (done !== !bad || error !== bad) begin errors++; $display("FAIL rnd%0d_status got d=%b e=%b want %b %b", f, done, error, !bad, bad); end
        end
    endtask

    task automatic test_zero_len();
        clear_log();
        pay.delete();
        do_start();
        send_frame(16'd0, 8'h00, 0);
        @(negedge clk);
        checks++; if (done !== 1'b1 || core_rst_n !== 1'b1) begin errors++; $display("FAIL zero_done got d=%b crst=%b want 1 1", done, core_rst_n); end
        checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL zero_nwr got %0d want 0", wr_addr_q.size()); end
        do_start();
        checks++; if (core_rst_n !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL zero_restart got crst=%b b=%b d=%b want 0 1 0", core_rst_n, busy, done); end
    endtask

    task automatic test_mid_reset();
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        clear_log();
        do_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
        @(negedge clk); rx_valid = 1'b0; rst_n = 1'b0;
        #1;
        checks++; if ({rx_ready, imem_we, core_rst_n, busy, done, error} !== 6'b0) begin errors++; $display("FAIL midrst_status got %b want 000000", {rx_ready, imem_we, core_rst_n, busy, done, error}); end
        checks++; if (imem_addr !== 32'h1000 || imem_wdata !== 32'h0) begin errors++; $display("FAIL midrst_bus got %h/%h want 00001000/0", imem_addr, imem_wdata); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (wr_addr_q.size() != 1) begin errors++; $display("FAIL midrst_nwr got %0d want 1", wr_addr_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_csum();
        test_too_long();
        test_random();
        test_zero_len();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
